fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side drainer for the team's synchronous circular FIFO. It issues rd_en only when the FIFO is non-empty and the drainer has room. It absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It presents the words as a valid/ready stream to downstream logic at up to one word per clock with no bubbles.

Parameters:
DW, 4, data width; must equal the FIFO data_out width.
BUF_DEPTH, 2, output buffer entries; fixed at 2, held in the package and not meant to be overridden.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset; clears all state immediately
fifo_data  input  DW  FIFO data_out; valid from the edge after a read was accepted
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  read strobe to FIFO (combinational)
m_data  output  DW  stream data, head of output buffer
m_valid  output  1  stream valid
m_ready  input  1  downstream accept

Behaviour:
- Reset (rst low, asynchronous): occ=0, pend=0, both buffer pointers=0, m_valid=0, m_data=0. fifo_rd_en is forced 0 while rst is low.
- pop = m_valid & m_ready. A word leaves the buffer at that edge.
- fifo_rd_en = rst & ~fifo_empty & ((occ + pend - pop) < 2). This is combinational from fifo_empty, m_ready and state. It is the only combinational input-to-output path.
- pend <= fifo_rd_en (1-bit register): a read was issued at this edge, so the data arrives on fifo_data during the following cycle.
- Capture: when pend==1, fifo_data is written into the buffer at wr_ptr on the next edge, and wr_ptr toggles.
- Word-level latency: read edge N, capture edge N+1, m_valid high after N+1. The earliest pop is edge N+2.
- occ update per edge: +1 on capture, -1 on pop, unchanged when both or neither occur. occ never exceeds 2; the rd_en gating guarantees this.
- Read side: m_data = buf[rd_ptr]. m_valid = (occ != 0). On pop, rd_ptr toggles. m_data/m_valid are held stable while m_valid & ~m_ready.
- Steady-state streaming (FIFO non-empty, m_ready=1): occ=1, pend=1, rd_en high every cycle, one word per clock.
- Backpressure (m_ready=0): at most 2 words are held (occ+pend=2) and rd_en deasserts. When m_ready returns, rd_en reasserts in the same cycle.
- fifo_empty rising while pend=1: the in-flight word is still captured. No new reads are issued.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO-side pointer is reset by the shared rst.
- Ordering: strict FIFO order, no duplication, no loss.

Optional Feature:
Macro FIFO_RD_XFER_CNT_EN.
- Defined: adds output xfer_cnt (16 bits). It is reset to 0, increments on every pop, and wraps from 16'hFFFF to 0. It also adds output stall (1 bit), registered, equal to m_valid & ~m_ready from the previous cycle, reset 0.
- Undefined: neither port nor their logic exists. Stream behaviour is identical.

Decomposition:
- Package fifo_rd_pkg holds:
  - BUF_DEPTH=2;
  - the pointer width constant (1);
  - XFER_CNT_W=16.
- Sub-module fifo_skid2 implements the 2-entry buffer. Its interface is push, push_data, pop, head data, occ.
- fifo_rd_stream keeps the pend register, rd_en gating and optional counters.

Test Plan:
- Reset with FIFO preloaded with 0x1..0x8, m_ready=1, then release rst. Required: rd_en high from the first cycle, m_valid high 2 edges after release, m_data sequence 1,2,...,8 on 8 consecutive cycles, then m_valid=0 and rd_en=0.
- Load 5 words, hold m_ready=0 for 10 cycles. Required: exactly 2 reads issued, occ=2, rd_en=0, m_data stable at the first word. Raise m_ready: all 5 words in order with no gap.
- Toggle m_ready 1,0,1,0 while the FIFO holds 0xA,0xB,0xC,0xD. Required: each word is delivered exactly once, in order, with m_data unchanged across stalled cycles.
- Single word 0x7 written into an empty FIFO. Required: rd_en pulses one cycle, m_valid rises 2 edges later and drops the cycle after the pop, fifo_empty is honoured, and no extra read occurs.
- Assert rst mid-stream with occ=2 and pend=1. Required: m_valid=0 and rd_en=0 immediately, asynchronously. After release, nothing stale is emitted.
- With FIFO_RD_XFER_CNT_EN, stream 20 words with 3 stall cycles. Required: xfer_cnt=20 and stall is high for exactly 3 cycles. Preload the counter to 0xFFFF by force, then pop once: required xfer_cnt=0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO read-side drainer and its 2-entry output buffer.
package fifo_rd_pkg;
  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned PTR_W      = 1;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned LOAD_W     = OCC_W + 1;
  localparam int unsigned XFER_CNT_W = 16;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry circular output buffer: push at wr_ptr, pop from rd_ptr, head is the oldest word.
module fifo_skid2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head,
  output logic [OCC_W-1:0] occ
);

  logic [DW-1:0]    mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage and pointers; caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read synchronous FIFO into a valid/ready stream without bubbles.
// Optional FIFO_RD_XFER_CNT_EN adds xfer_cnt (pop counter) and stall (registered backpressure flag).
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DW-1:0]         m_data,
  output logic                  m_valid,
`ifdef FIFO_RD_XFER_CNT_EN
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  stall,
`endif
  input  logic                  m_ready
);

  logic             pend;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [LOAD_W-1:0] load;

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;

  // Words held or in flight after this edge's pop; a read is only safe while this is below the buffer size.
  assign load       = LOAD_W'(occ) + LOAD_W'(pend) - LOAD_W'(pop);
  assign fifo_rd_en = rst & ~fifo_empty & (load < LOAD_W'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
    end
  end

  fifo_skid2 #(
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (pend),
    .push_data(fifo_data),
    .pop      (pop),
    .head     (m_data),
    .occ      (occ)
  );

`ifdef FIFO_RD_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
      end
      stall <= m_valid & ~m_ready;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO environment, queue-based reference model, per-cycle compare and directed tests.
module tb_fifo_rd_stream;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef FIFO_RD_XFER_CNT_EN
  logic [15:0]   xfer_cnt;
  logic          stall;
`endif

  fifo_rd_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
`ifdef FIFO_RD_XFER_CNT_EN
    .xfer_cnt  (xfer_cnt),
    .stall     (stall),
`endif
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  // Environment FIFO with one-cycle registered read; cleared only by fifo_flush
  logic [DW-1:0] fmem [64];
  logic [DW-1:0] wlog [256];
  int            fwp, frp, fcnt, wcnt;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          fifo_flush;

  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (fifo_flush) begin
      fwp  <= 0;
      frp  <= 0;
      fcnt <= 0;
    end else begin
      if (fifo_rd_en) begin
        fifo_data <= fmem[frp];
        frp       <= (frp + 1) % 64;
      end
      if (wr_en) begin
        fmem[fwp]  <= wr_data;
        fwp        <= (fwp + 1) % 64;
        wlog[wcnt % 256] <= wr_data;
        wcnt       <= wcnt + 1;
      end
      fcnt <= fcnt + int'(wr_en) - int'(fifo_rd_en);
    end
  end

  // Reference model: words visible downstream plus at most one word in flight from the FIFO
  logic [DW-1:0] mq[$];
  bit            m_inf;
  logic [DW-1:0] m_inf_val;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_inf = 1'b0;
    end else begin
      bit pop_m;
      bit rd_m;
      pop_m = (mq.size() > 0) && m_ready;
      rd_m  = (fcnt > 0) && ((mq.size() + int'(m_inf) - int'(pop_m)) < 2);
      if (pop_m) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_val);
      m_inf = rd_m;
      if (rd_m) m_inf_val = fmem[frp];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  int scnt = 0;
  int stall_cnt = 0;
  logic [DW-1:0] pop_word [256];
  int            pop_cyc  [256];
  bit            prev_hold;
  logic [DW-1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (fifo_flush) scnt = wcnt;
    if (!rst) begin
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_m_data", int'(m_data), 0);
      prev_hold = 1'b0;
    end else begin
      bit ev;
      int er;
      ev = mq.size() > 0;
      er = int'((fcnt > 0) && ((mq.size() + int'(m_inf) - int'(ev && m_ready)) < 2));
      chk("m_valid", int'(m_valid), int'(ev));
      chk("rd_en", int'(fifo_rd_en), er);
      if (ev) chk("m_data", int'(m_data), int'(mq[0]));
      if (prev_hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(prev_data));
      end
`ifdef FIFO_RD_XFER_CNT_EN
      chk("stall", int'(stall), int'(prev_hold));
      if (stall) stall_cnt++;
`endif
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) begin
        if (scnt >= wcnt) chk("extra_pop", 1, 0);
        else begin
          chk("order", int'(m_data), int'(wlog[scnt % 256]));
          scnt++;
        end
        pop_word[pop_cnt % 256] = m_data;
        pop_cyc[pop_cnt % 256]  = cyc;
        pop_cnt++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  logic [DW-1:0] vec2 [5];
  logic [DW-1:0] vec3 [4];

  initial begin
    int rel, base_pop, base_rd;
    vec2[0] = 4'h3; vec2[1] = 4'h5; vec2[2] = 4'h9; vec2[3] = 4'hC; vec2[4] = 4'hE;
    vec3[0] = 4'hA; vec3[1] = 4'hB; vec3[2] = 4'hC; vec3[3] = 4'hD;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; m_ready = 1'b0; fifo_flush = 1'b1;
    #2 rst = 1'b0;
    step();
    fifo_flush = 1'b0;

    // Test 1: preload 1..8 under reset, release with m_ready=1
    for (int i = 1; i <= 8; i++) write_word(DW'(i));
    m_ready  = 1'b1;
    rst      = 1'b1;
    rel      = cyc;
    base_pop = pop_cnt;
    @(negedge clk);
    chk("t1_rd_first_cycle", int'(fifo_rd_en), 1);
    chk("t1_valid_not_yet", int'(m_valid), 0);
    repeat (12) step();
    chk("t1_pop_count", pop_cnt - base_pop, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_word", int'(pop_word[(base_pop + i) % 256]), i + 1);
      chk("t1_word_cycle", pop_cyc[(base_pop + i) % 256], rel + 2 + i);
    end
    @(negedge clk);
    chk("t1_end_valid", int'(m_valid), 0);
    chk("t1_end_rd_en", int'(fifo_rd_en), 0);

    // Test 2: 5 words under 10 cycles of backpressure
    step();
    m_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 5; i++) write_word(vec2[i]);
    repeat (10) step();
    @(negedge clk);
    chk("t2_reads_issued", rd_cnt - base_rd, 2);
    chk("t2_occ", int'(dut.u_buf.occ), 2);
    chk("t2_rd_en_low", int'(fifo_rd_en), 0);
    chk("t2_valid", int'(m_valid), 1);
    chk("t2_head", int'(m_data), 3);
    step();
    base_pop = pop_cnt;
    m_ready  = 1'b1;
    rel      = cyc;
    repeat (8) step();
    chk("t2_pop_count", pop_cnt - base_pop, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_word", int'(pop_word[(base_pop + i) % 256]), int'(vec2[i]));
      chk("t2_no_gap", pop_cyc[(base_pop + i) % 256], rel + i);
    end

    // Test 3: alternating m_ready over A,B,C,D
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(vec3[i]);
    repeat (4) step();
    base_pop = pop_cnt;
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    m_ready = 1'b1;
    repeat (4) step();
    chk("t3_pop_count", pop_cnt - base_pop, 4);
    for (int i = 0; i < 4; i++)
      chk("t3_word", int'(pop_word[(base_pop + i) % 256]), int'(vec3[i]));

    // Test 4: single word into an empty FIFO
    base_rd  = rd_cnt;
    base_pop = pop_cnt;
    write_word(4'h7);
    rel = cyc;
    repeat (6) step();
    chk("t4_single_read", rd_cnt - base_rd, 1);
    chk("t4_single_pop", pop_cnt - base_pop, 1);
    chk("t4_word", int'(pop_word[base_pop % 256]), 7);
    chk("t4_latency", pop_cyc[base_pop % 256], rel + 2);
    @(negedge clk);
    chk("t4_valid_dropped", int'(m_valid), 0);

    // Test 5: asynchronous reset with a full buffer
    step();
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) write_word(DW'(i));
    repeat (3) step();
    chk("t5_occ_full", int'(dut.u_buf.occ), 2);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_valid", int'(m_valid), 0);
    chk("t5_async_rd_en", int'(fifo_rd_en), 0);
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
    step();
    rst      = 1'b1;
    m_ready  = 1'b1;
    base_pop = pop_cnt;
    base_rd  = rd_cnt;
    repeat (6) step();
    chk("t5_no_stale_pop", pop_cnt - base_pop, 0);
    chk("t5_no_stale_read", rd_cnt - base_rd, 0);

`ifdef FIFO_RD_XFER_CNT_EN
    // Test 6: counters over 20 words with 3 stall cycles, then wrap
    begin
      int base_stall;
      base_stall = stall_cnt;
      for (int i = 0; i < 20; i++) begin
        m_ready = !(i >= 10 && i < 13);
        wr_en   = 1'b1;
        wr_data = DW'(i % 16);
        step();
      end
      wr_en   = 1'b0;
      m_ready = 1'b1;
      repeat (8) step();
      chk("t6_xfer_cnt", int'(xfer_cnt), 20);
      chk("t6_stall_cycles", stall_cnt - base_stall, 3);
      force dut.xfer_cnt = 16'hFFFF;
      #1 release dut.xfer_cnt;
      chk("t6_forced", int'(xfer_cnt), 16'hFFFF);
      write_word(4'h5);
      repeat (5) step();
      chk("t6_wrap", int'(xfer_cnt), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
